alu_result_buffer: RTL and testbench

Consumer end of the ALU functional-unit result interface. It accepts the registered result word and the one-cycle-per-result flag produced by the arithmetic, logic and shift units. Accepted words are buffered in a small first-word-fall-through FIFO and presented downstream on a valid/ready handshake. Results that arrive while the buffer is full are dropped and counted.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_buf_ram.sv | 25 ++
 rtl/alu_result_buffer.sv | 104 ++++++++++
 tb/tb_alu_result_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU result-path definitions: result width, parity helper and
// buffer level-width helper used by the ALU-side buffers.
package alu_pkg;

    localparam int unsigned ALU_RES_W = 17;

    // Zero-extension by the caller leaves the parity unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

    // A level counter has to hold 0..depth inclusive.
    function automatic int unsigned buf_lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_buf_ram.sv
// DEPTH x WIDTH register array with synchronous write and asynchronous read.
// Storage is intentionally left unreset.
module alu_buf_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_buffer.sv
// FWFT result buffer behind the ALU functional units; overflow drops are counted.
// Define ALU_RESULT_BUFFER_PARITY_EN to store per-entry parity and add out_parity/parity_err.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_RES_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_flag,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          full,
    output logic                          empty,
    output logic [buf_lvl_w(DEPTH)-1:0]   level,
    output logic [CNT_W-1:0]              drop_cnt
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    ,
    output logic                          out_parity,
    output logic                          parity_err
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = buf_lvl_w(DEPTH);
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    localparam int unsigned ENTRY_W = DATA_W + 1;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign out_valid = ~empty;
    assign level     = level_q;
    assign drop_cnt  = drop_cnt_q;

    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign pop  = out_valid & out_ready;
    assign push = in_flag & (~full | pop);
    assign drop = in_flag & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef ALU_RESULT_BUFFER_PARITY_EN
    assign wr_entry   = {even_parity(64'(in_data)), in_data};
    assign out_data   = rd_entry[DATA_W-1:0];
    assign out_parity = rd_entry[DATA_W];
    assign parity_err = out_valid & ((^out_data) != out_parity);
`else
    assign wr_entry   = in_data;
    assign out_data   = rd_entry;
`endif

    alu_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer against a queue-based reference model.
// A second instance with a 2-bit drop counter shares the stimulus to cover saturation.
module tb_alu_result_buffer;

    localparam int unsigned DATA_W = 17;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_flag = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;

    logic              out_valid, full, empty;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        level;
    logic [7:0]        drop_cnt;
    logic              s_out_valid, s_full, s_empty;
    logic [DATA_W-1:0] s_out_data;
    logic [2:0]        s_level;
    logic [1:0]        s_drop_cnt;
`ifdef ALU_RESULT_BUFFER_PARITY_EN
    logic              out_parity, parity_err, s_out_parity, s_parity_err;
`endif

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_flag(in_flag), .in_data(in_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .full(full), .empty(empty),
        .level(level), .drop_cnt(drop_cnt)
`ifdef ALU_RESULT_BUFFER_PARITY_EN
        , .out_parity(out_parity), .parity_err(parity_err)
`endif
    );

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_flag(in_flag), .in_data(in_data), .out_ready(out_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .full(s_full), .empty(s_empty),
        .level(s_level), .drop_cnt(s_drop_cnt)
`ifdef ALU_RESULT_BUFFER_PARITY_EN
        , .out_parity(s_out_parity), .parity_err(s_parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [DATA_W-1:0] model_q[$];
    int unsigned       drops_total = 0;

    function automatic int unsigned exp_drop(input int unsigned w);
        int unsigned mx;
        mx = (1 << w) - 1;
        return (drops_total > mx) ? mx : drops_total;
    endfunction

    // One clock of stimulus; the model is updated from the behavioural rules.
    task automatic cycle(input logic f, input logic [DATA_W-1:0] d, input logic r);
        bit pop_m, full_m;
        @(negedge clk);
        in_flag = f; in_data = d; out_ready = r;
        pop_m  = (model_q.size() != 0) && r;
        full_m = (model_q.size() == DEPTH);
        if (pop_m) void'(model_q.pop_front());
        if (f && (!full_m || pop_m)) model_q.push_back(d);
        else if (f) drops_total++;
        @(posedge clk);
        #1;
        in_flag = 1'b0; out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        drops_total = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        while (model_q.size() != 0) cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        cmp_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b want 1", empty); end
        cmp_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b want 0", full); end
        cmp_cnt++; if (level !== 3'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", level); end
        cmp_cnt++; if (drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fifo_order();
        logic [DATA_W-1:0] exp_w [3];
        exp_w[0] = 17'h00001; exp_w[1] = 17'h1FFFF; exp_w[2] = 17'h0AAAA;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_w[i], 1'b0);
        cmp_cnt++; if (level !== 3'd3) begin err_cnt++; $display("FAIL order_level: got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            cmp_cnt++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
                err_cnt++;
                $display("FAIL order_word%0d: got v=%b %h want v=1 %h", i, out_valid, out_data, exp_w[i]);
            end
            cycle(1'b0, '0, 1'b1);
        end
        cmp_cnt++; if (empty !== 1'b1 || level !== 3'd0) begin
            err_cnt++; $display("FAIL order_empty: got empty=%b level=%0d want 1/0", empty, level); end
    endtask

    task automatic test_overflow_drop();
        logic [DATA_W-1:0] head;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'($urandom), 1'b0);
        head = model_q[0];
        for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'($urandom), 1'b0);
        cmp_cnt++; if (full !== 1'b1 || level !== 3'd4) begin
            err_cnt++; $display("FAIL ovf_full: got full=%b level=%0d want 1/4", full, level); end
        cmp_cnt++; if (drop_cnt !== 8'd3) begin err_cnt++; $display("FAIL ovf_drop: got %0d want 3", drop_cnt); end
        cmp_cnt++; if (out_data !== head) begin err_cnt++; $display("FAIL ovf_head: got %h want %h", out_data, head); end
    endtask

    task automatic test_full_push_pop();
        cycle(1'b1, 17'h12345, 1'b1);
        cmp_cnt++; if (level !== 3'd4 || full !== 1'b1) begin
            err_cnt++; $display("FAIL fpp_level: got level=%0d full=%b want 4/1", level, full); end
        cmp_cnt++; if (drop_cnt !== 8'd3) begin err_cnt++; $display("FAIL fpp_drop: got %0d want 3", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            cmp_cnt++;
            if (out_data !== model_q[0]) begin
                err_cnt++; $display("FAIL fpp_word%0d: got %h want %h", i, out_data, model_q[0]); end
            if (i == 3) begin
                cmp_cnt++;
                if (out_data !== 17'h12345) begin
                    err_cnt++; $display("FAIL fpp_last: got %h want 12345", out_data); end
            end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_drop_saturation();
        logic [1:0] exp_s [5];
        exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3; exp_s[4] = 2'd3;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, DATA_W'($urandom), 1'b0);
            cmp_cnt++; if (s_drop_cnt !== exp_s[i]) begin
                err_cnt++; $display("FAIL sat2_drop%0d: got %0d want %0d", i, s_drop_cnt, exp_s[i]); end
            cmp_cnt++; if (drop_cnt !== 8'(i + 1)) begin
                err_cnt++; $display("FAIL sat8_drop%0d: got %0d want %0d", i, drop_cnt, i + 1); end
        end
        for (int i = 0; i < 255; i++) cycle(1'b1, DATA_W'($urandom), 1'b0);
        cmp_cnt++; if (drop_cnt !== 8'(exp_drop(8))) begin
            err_cnt++; $display("FAIL sat8_final: got %0d want %0d", drop_cnt, exp_drop(8)); end
        cmp_cnt++; if (drop_cnt !== 8'd255) begin
            err_cnt++; $display("FAIL sat8_nowrap: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_async_reset();
        drain();
        cycle(1'b1, DATA_W'($urandom), 1'b0);
        cycle(1'b1, DATA_W'($urandom), 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        cmp_cnt++; if (out_valid !== 1'b0 || empty !== 1'b1) begin
            err_cnt++; $display("FAIL arst_valid: got v=%b e=%b want 0/1", out_valid, empty); end
        cmp_cnt++; if (level !== 3'd0) begin err_cnt++; $display("FAIL arst_level: got %0d want 0", level); end
        cmp_cnt++; if (drop_cnt !== 8'd0 || s_drop_cnt !== 2'd0) begin
            err_cnt++; $display("FAIL arst_drop: got %0d/%0d want 0/0", drop_cnt, s_drop_cnt); end
        model_q.delete();
        drops_total = 0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 17'h0BEEF, 1'b0);
        cmp_cnt++; if (out_valid !== 1'b1 || out_data !== 17'h0BEEF || level !== 3'd1) begin
            err_cnt++;
            $display("FAIL arst_after: got v=%b d=%h l=%0d want 1/0beef/1", out_valid, out_data, level);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), DATA_W'($urandom), 1'($urandom_range(0, 1)));
            cmp_cnt++; if (level !== 3'(model_q.size())) begin
                err_cnt++; $display("FAIL rnd_level@%0d: got %0d want %0d", i, level, model_q.size()); end
            cmp_cnt++; if (out_valid !== (model_q.size() != 0) || empty !== (model_q.size() == 0)
                           || full !== (model_q.size() == DEPTH)) begin
                err_cnt++; $display("FAIL rnd_flags@%0d: got v=%b e=%b f=%b want size %0d",
                                    i, out_valid, empty, full, model_q.size());
            end
            cmp_cnt++; if (drop_cnt !== 8'(exp_drop(8)) || s_drop_cnt !== 2'(exp_drop(2))) begin
                err_cnt++; $display("FAIL rnd_drop@%0d: got %0d/%0d want %0d/%0d",
                                    i, drop_cnt, s_drop_cnt, exp_drop(8), exp_drop(2));
            end
            if (model_q.size() != 0) begin
                cmp_cnt++; if (out_data !== model_q[0]) begin
                    err_cnt++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, model_q[0]); end
            end
        end
    endtask

`ifdef ALU_RESULT_BUFFER_PARITY_EN
    task automatic test_parity();
        drain();
        cycle(1'b1, 17'h00007, 1'b0);
        cmp_cnt++; if (out_parity !== 1'b1 || parity_err !== 1'b0) begin
            err_cnt++; $display("FAIL par_seven: got p=%b err=%b want 1/0", out_parity, parity_err); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DATA_W'($urandom), 1'($urandom_range(0, 1)));
            cmp_cnt++; if (parity_err !== 1'b0) begin
                err_cnt++; $display("FAIL par_err@%0d: got %b want 0", i, parity_err); end
            if (model_q.size() != 0) begin
                cmp_cnt++; if (out_parity !== (^model_q[0])) begin
                    err_cnt++; $display("FAIL par_bit@%0d: got %b want %b", i, out_parity, ^model_q[0]); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow_drop();
        test_full_push_pop();
        test_drop_saturation();
        test_async_reset();
        test_random();
`ifdef ALU_RESULT_BUFFER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
